step1_twiddle: RTL and testbench

Twiddle-multiply stage of the 512-point radix-2² DIF FFT pipeline. Sits directly downstream of the step-1 butterfly (`step1_1`) and consumes its 16-lane, 14-bit complex output stream. Each 32-cycle frame holds samples n = 16·cycle + lane. The block multiplies every sample by W₅₁₂^e, then rounds and saturates back to 14 bits for the next butterfly stage.

---
 rtl/step1_twiddle_if.sv | 26 ++
 rtl/step1_twiddle.sv | 166 ++++++++++++++++
 tb/tb_step1_twiddle.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/step1_twiddle_if.sv
// step1_twiddle_if: 16-lane complex sample stream through the step-1 twiddle stage.
// Ports: din_valid/din_r/din_i go from the upstream butterfly into the stage.
//        dout_valid/dout_r/dout_i/dout_idx go from the stage to the next butterfly.
//        There is no ready signal: the stream never stalls.
interface step1_twiddle_if #(
  parameter int DIN_W  = 14,
  parameter int DOUT_W = 14
);
  logic                     din_valid;
  logic signed [DIN_W-1:0]  din_r [16];
  logic signed [DIN_W-1:0]  din_i [16];
  logic                     dout_valid;
  logic signed [DOUT_W-1:0] dout_r [16];
  logic signed [DOUT_W-1:0] dout_i [16];
  logic [4:0]               dout_idx;

  modport master (
    output din_valid, din_r, din_i,
    input  dout_valid, dout_r, dout_i, dout_idx
  );

  modport slave (
    input  din_valid, din_r, din_i,
    output dout_valid, dout_r, dout_i, dout_idx
  );
endinterface

// File: rtl/step1_twiddle.sv
// step1_twiddle: multiplies each of 16 lanes by W512^e, then rounds and saturates to DOUT_W.
// Latency: 3 cycles (S1 lookup/register, S2 partial products, S3 sum/round/saturate).
// Backpressure: none; dout_valid is din_valid delayed by 3 cycles, with gaps preserved.
// Ports: clk, rstn (async active-low), bus (slave side of step1_twiddle_if).
module step1_twiddle #(
  parameter int DIN_W  = 14,
  parameter int TW_W   = 10,
  parameter int DOUT_W = 14
) (
  input  logic           clk,
  input  logic           rstn,
  step1_twiddle_if.slave bus
);
  localparam int LANES  = 16;
  localparam int FRAC   = TW_W - 2;          // Q1.8 coefficients: 256 = 1.0
  localparam int PP_W   = DIN_W + TW_W;      // one partial product
  localparam int SUM_W  = PP_W + 1;          // a*c - b*d at full precision
  localparam int SUM_W1 = SUM_W + 1;         // headroom for the rounding offset
  localparam logic signed [SUM_W:0] RND   = SUM_W1'(1 << (FRAC - 1));
  localparam logic signed [SUM_W:0] Y_MAX = SUM_W1'((1 << (DOUT_W - 1)) - 1);
  localparam logic signed [SUM_W:0] Y_MIN = ~Y_MAX;

  // round(256*sin(k*pi/256)) for k = 0..128; the other quadrants come from symmetry.
  localparam logic [8:0] QSIN [129] = '{
    0,3,6,9,13,16,19,22,25,28,31,34,38,41,44,47,
    50,53,56,59,62,65,68,71,74,77,80,83,86,89,92,95,
    98,101,104,107,109,112,115,118,121,123,126,129,132,134,137,140,
    142,145,147,150,152,155,157,160,162,165,167,170,172,174,177,179,
    181,183,185,188,190,192,194,196,198,200,202,204,206,207,209,211,
    213,215,216,218,220,221,223,224,226,227,229,230,231,233,234,235,
    237,238,239,240,241,242,243,244,245,246,247,248,248,249,250,250,
    251,252,252,253,253,254,254,254,255,255,255,256,256,256,256,256,
    256
  };

  typedef struct packed {
    logic signed [TW_W-1:0] c;   // cos part
    logic signed [TW_W-1:0] d;   // -sin part
  } tw_t;

  // n = 16*cyc + lane; q = n[8:7] picks the multiplier {0,2,1,3}, r = n[6:0].
  function automatic tw_t tw_lookup(input logic [4:0] cyc, input logic [3:0] lane);
    logic [6:0]             r;
    logic [8:0]             e;
    logic [7:0]             f;
    logic [7:0]             g;
    logic signed [TW_W-1:0] s_f;
    logic signed [TW_W-1:0] s_g;
    tw_t                    t;
    r = {cyc[2:0], lane};
    case (cyc[4:3])
      2'd0:    e = 9'd0;
      2'd1:    e = {1'b0, r, 1'b0};
      2'd2:    e = {2'b00, r};
      default: e = {1'b0, r, 1'b0} + {2'b00, r};   // 3*r never exceeds 381
    endcase
    f   = {1'b0, e[6:0]};
    g   = 8'd128 - f;
    s_f = TW_W'(QSIN[f]);   // sin of the in-quadrant angle
    s_g = TW_W'(QSIN[g]);   // cos of the in-quadrant angle
    case (e[8:7])
      2'd0:    begin t.c =  s_g; t.d = -s_f; end
      2'd1:    begin t.c = -s_f; t.d = -s_g; end
      2'd2:    begin t.c = -s_g; t.d =  s_f; end
      default: begin t.c =  s_f; t.d =  s_g; end
    endcase
    return t;
  endfunction

  // Round half up, then clamp into the DOUT_W signed range.
  function automatic logic signed [DOUT_W-1:0] rnd_sat(input logic signed [SUM_W-1:0] p);
    logic signed [SUM_W:0]   y;
    logic signed [DOUT_W-1:0] o;
    y = (SUM_W1'(p) + RND) >>> FRAC;
    if (y > Y_MAX)      o = DOUT_W'(Y_MAX);
    else if (y < Y_MIN) o = DOUT_W'(Y_MIN);
    else                o = DOUT_W'(y);
    return o;
  endfunction

  logic [4:0]               r_cyc;
  logic                     r_v1, r_v2, r_v3;
  logic [4:0]               r_idx1, r_idx2, r_idx3;
  logic signed [DIN_W-1:0]  r_a1 [LANES];
  logic signed [DIN_W-1:0]  r_b1 [LANES];
  logic signed [TW_W-1:0]   r_c1 [LANES];
  logic signed [TW_W-1:0]   r_d1 [LANES];
  logic signed [PP_W-1:0]   r_ac2 [LANES];
  logic signed [PP_W-1:0]   r_bd2 [LANES];
  logic signed [PP_W-1:0]   r_ad2 [LANES];
  logic signed [PP_W-1:0]   r_bc2 [LANES];
  logic signed [DOUT_W-1:0] r_yr3 [LANES];
  logic signed [DOUT_W-1:0] r_yi3 [LANES];

  tw_t                      w_tw [LANES];
  logic signed [SUM_W-1:0]  w_pr [LANES];
  logic signed [SUM_W-1:0]  w_pi [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_tw[l] = tw_lookup(r_cyc, 4'(l));
      w_pr[l] = SUM_W'(r_ac2[l]) - SUM_W'(r_bd2[l]);
      w_pi[l] = SUM_W'(r_ad2[l]) + SUM_W'(r_bc2[l]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cyc  <= '0;
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_idx1 <= '0;
      r_idx2 <= '0;
      r_idx3 <= '0;
      for (int l = 0; l < LANES; l++) begin
        r_a1[l]  <= '0;
        r_b1[l]  <= '0;
        r_c1[l]  <= '0;
        r_d1[l]  <= '0;
        r_ac2[l] <= '0;
        r_bd2[l] <= '0;
        r_ad2[l] <= '0;
        r_bc2[l] <= '0;
        r_yr3[l] <= '0;
        r_yi3[l] <= '0;
      end
    end else begin
      r_v1 <= bus.din_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      // Each stage loads only on its own valid, so idle cycles freeze the data path.
      if (bus.din_valid) begin
        r_cyc  <= r_cyc + 5'd1;
        r_idx1 <= r_cyc;
        for (int l = 0; l < LANES; l++) begin
          r_a1[l] <= bus.din_r[l];
          r_b1[l] <= bus.din_i[l];
          r_c1[l] <= w_tw[l].c;
          r_d1[l] <= w_tw[l].d;
        end
      end
      if (r_v1) begin
        r_idx2 <= r_idx1;
        for (int l = 0; l < LANES; l++) begin
          r_ac2[l] <= PP_W'(r_a1[l]) * PP_W'(r_c1[l]);
          r_bd2[l] <= PP_W'(r_b1[l]) * PP_W'(r_d1[l]);
          r_ad2[l] <= PP_W'(r_a1[l]) * PP_W'(r_d1[l]);
          r_bc2[l] <= PP_W'(r_b1[l]) * PP_W'(r_c1[l]);
        end
      end
      if (r_v2) begin
        r_idx3 <= r_idx2;
        for (int l = 0; l < LANES; l++) begin
          r_yr3[l] <= rnd_sat(w_pr[l]);
          r_yi3[l] <= rnd_sat(w_pi[l]);
        end
      end
    end
  end

  assign bus.dout_valid = r_v3;
  assign bus.dout_idx   = r_idx3;
  assign bus.dout_r     = r_yr3;
  assign bus.dout_i     = r_yi3;
endmodule

// File: tb/tb_step1_twiddle.sv
// tb_step1_twiddle: directed vectors with hand-computed products for step1_twiddle.
// Latency: checks outputs 3 cycles after each driven input, on the falling edge.
// Backpressure: none in the DUT; the bench streams frames with and without gaps.
module tb_step1_twiddle;
  logic clk = 1'b0;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;
  int   tb_cyc   = 0;
  logic [2:0] vh;

  typedef struct packed {
    int idx;
    int mode;   // 0: index only, 1: every lane = (er0, ei0), 2: lanes 0 and 1
    int er0;
    int ei0;
    int er1;
    int ei1;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  step1_twiddle_if #(.DIN_W(14), .DOUT_W(14)) bus ();

  step1_twiddle #(.DIN_W(14), .TW_W(10), .DOUT_W(14)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // Lane 0 gets (ar, ai), lanes 1..15 get (br, bi).
  task automatic send(input int ar, ai, br, bi, input int mode, input int er0, ei0, er1, ei1);
    exp_t t;
    bus.din_valid = 1'b1;
    bus.din_r[0]  = 14'(ar);
    bus.din_i[0]  = 14'(ai);
    for (int l = 1; l < 16; l++) begin
      bus.din_r[l] = 14'(br);
      bus.din_i[l] = 14'(bi);
    end
    t.idx  = tb_cyc;
    t.mode = mode;
    t.er0  = er0;
    t.ei0  = ei0;
    t.er1  = er1;
    t.ei1  = ei1;
    exp_q.push_back(t);
    tb_cyc = (tb_cyc + 1) % 32;
    @(negedge clk);
  endtask

  task automatic zeros(input int n);
    for (int k = 0; k < n; k++) send(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    bus.din_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Required dout_valid: din_valid as seen at the last three rising edges.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) vh <= 3'b000;
    else       vh <= {vh[1:0], bus.din_valid};
  end

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      chk("valid", int'(bus.dout_valid), int'(vh[2]));
      if (bus.dout_valid === 1'b1) begin
        chk("exp_avail", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          chk("idx", int'(bus.dout_idx), cur.idx);
          if (cur.mode == 1) begin
            for (int l = 0; l < 16; l++) begin
              chk($sformatf("all_r[%0d]@%0d", l, cur.idx), int'(bus.dout_r[l]), cur.er0);
              chk($sformatf("all_i[%0d]@%0d", l, cur.idx), int'(bus.dout_i[l]), cur.ei0);
            end
          end else if (cur.mode == 2) begin
            chk($sformatf("l0_r@%0d", cur.idx), int'(bus.dout_r[0]), cur.er0);
            chk($sformatf("l0_i@%0d", cur.idx), int'(bus.dout_i[0]), cur.ei0);
            chk($sformatf("l1_r@%0d", cur.idx), int'(bus.dout_r[1]), cur.er1);
            chk($sformatf("l1_i@%0d", cur.idx), int'(bus.dout_i[1]), cur.ei1);
          end
        end
      end
    end
  end

  initial begin
    rstn = 1'b0;
    bus.din_valid = 1'b0;
    for (int l = 0; l < 16; l++) begin
      bus.din_r[l] = '0;
      bus.din_i[l] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(bus.dout_valid), 0);
    chk("rst_idx",   int'(bus.dout_idx), 0);
    chk("rst_r0",    int'(bus.dout_r[0]), 0);
    chk("rst_i15",   int'(bus.dout_i[15]), 0);
    #2 rstn = 1'b1;
    @(negedge clk);
    idle(4);

    // Frame A: identity region, small twiddle, -j twiddle, positive saturation.
    for (int c = 0; c < 8; c++) send(1000, -500, 1000, -500, 1, 1000, -500, 0, 0);
    send(1000, 0, 1000, 0, 2, 1000, 0, 1000, -23);            // cyc 8, e = 0 / 2
    zeros(3);
    send(1000, 300, 1000, 300, 2, 300, -1000, 277, -1007);    // cyc 12, e = 128 / 130
    zeros(7);
    send(8191, 8191, 0, 0, 2, 8191, 0, 0, 0);                 // cyc 20, e = 64
    zeros(11);

    // Frame B back-to-back: wrap to e = 0, negative saturation, third quadrant.
    send(1000, -500, 1000, -500, 1, 1000, -500, 0, 0);        // cyc 0
    zeros(19);
    send(8191, -8191, 0, 0, 2, 0, -8192, 0, 0);               // cyc 20, e = 64
    zeros(10);
    send(256, 0, 256, 0, 2, -142, 213, -134, 218);            // cyc 31, e = 336 / 339
    idle(6);
    chk("hold_r0", int'(bus.dout_r[0]), -142);
    chk("hold_i1", int'(bus.dout_i[1]), 218);

    // 16 valid, 5 idle, 16 valid: index and twiddles continue across the gap.
    for (int c = 0; c < 8; c++) send(1000, -500, 1000, -500, 1, 1000, -500, 0, 0);
    send(1000, 0, 1000, 0, 2, 1000, 0, 1000, -23);            // cyc 8
    zeros(7);
    idle(5);
    send(1000, 0, 1000, 0, 2, 1000, 0, 1000, -12);            // cyc 16, e = 0 / 1
    zeros(3);
    send(8191, 8191, 0, 0, 2, 8191, 0, 0, 0);                 // cyc 20
    zeros(11);
    idle(4);

    // Reset pulse at cycle 10 of a frame.
    for (int c = 0; c < 8; c++) send(1000, -500, 1000, -500, 1, 1000, -500, 0, 0);
    send(1000, 0, 1000, 0, 2, 1000, 0, 1000, -23);
    zeros(1);
    bus.din_valid = 1'b0;
    chk("pre_rst_valid", int'(bus.dout_valid), 1);
    chk("pre_rst_r0",    int'(bus.dout_r[0]), 1000);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_valid", int'(bus.dout_valid), 0);
    chk("mid_rst_idx",   int'(bus.dout_idx), 0);
    chk("mid_rst_r0",    int'(bus.dout_r[0]), 0);
    chk("mid_rst_i0",    int'(bus.dout_i[0]), 0);
    exp_q.delete();
    tb_cyc = 0;
    @(negedge clk);
    #2 rstn = 1'b1;
    for (int c = 0; c < 8; c++) send(1000, 0, 1000, 0, 1, 1000, 0, 0, 0);
    send(1000, 0, 1000, 0, 2, 1000, 0, 1000, -23);
    idle(1);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
